if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It owns the PC, drives the synchronous instruction SRAM, and applies redirects from decode-stage branches and exception flushes. It hands decode a registered `pc_o` / `inst_o` / `is_in_delayslot_o` triple, and a skid buffer keeps the fetched instruction stable across stalls.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC value after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  hold the PC and the IF/ID register; from the hazard/stall controller.
- `flush_i`  in  1  exception/eret redirect; kills the IF/ID contents.
- `new_pc_i`  in  32  redirect target used when `flush_i`=1.
- `branch_flag_i`  in  1  decode resolved a taken branch/jump this cycle.
- `branch_to_addr_i`  in  32  target used when `branch_flag_i`=1.
- `next_is_in_delayslot_i`  in  1  the instruction now being fetched is a delay slot.
- `inst_sram_en_o`  out  1  SRAM read enable.
- `inst_sram_addr_o`  out  32  SRAM byte address; equals `pc_q`.
- `inst_sram_rdata_i`  in  32  SRAM read data, valid the cycle after the address.
- `pc_o`  out  32  PC of the instruction presented to decode.
- `inst_o`  out  32  instruction presented to decode; 0 (nop) when invalid.
- `is_in_delayslot_o`  out  1  delay-slot flag for the decode instruction.
- `fetch_adel_o`  out  1  fetch address misaligned (AdEL); `pc_o` is the bad address.

## Operation
- **Fetch PC `pc_q`:**
  - Reset value `RESET_PC`.
  - Next-PC priority: `flush_i` → `new_pc_i`; else `stall_i` → hold; else `branch_flag_i` → `branch_to_addr_i`; else `pc_q`+4, with 32-bit wrap and no overflow detection.
- **IF/ID register** (`id_pc_q`, `id_valid_q`, `id_ds_q`, `id_adel_q`):
  - Reset and flush: all cleared to 0.
  - Stall without flush: hold.
  - Otherwise capture `pc_q`, valid=1, `next_is_in_delayslot_i`, and (`pc_q[1:0]`≠0).
- **SRAM enable:** `inst_sram_en_o` = !`rst` & (!`stall_i` | `flush_i`) & (`pc_q[1:0]`==0).
- **Skid buffer** (`held_q`, `held_valid_q`):
  - On the first stalled cycle with `id_valid_q`=1 and `held_valid_q`=0, capture `inst_sram_rdata_i`.
  - `held_valid_q` clears on any unstalled cycle or on flush.
- **inst_o select:**
  - 0 if !`id_valid_q` or `id_adel_q`.
  - Else `held_q` if `held_valid_q`.
  - Else `inst_sram_rdata_i`.
- **Branch handling:** the instruction fetched while `branch_flag_i`=1 is the delay slot and is not killed; its ID entry carries `is_in_delayslot_o`=1.
- **Outputs:** `pc_o`=`id_pc_q`, `is_in_delayslot_o`=`id_ds_q`, `fetch_adel_o`=`id_adel_q`.

## Timing
- **Reset values:**
  - `inst_sram_addr_o`=`RESET_PC`, `inst_sram_en_o`=0 while `rst`=1.
  - `pc_o`=0, `inst_o`=0, `is_in_delayslot_o`=0, `fetch_adel_o`=0.
- **Latency:** address at edge n → instruction on `inst_o` with matching `pc_o` from edge n+1; one instruction per cycle when unstalled.
- **Branch:** `branch_flag_i` sampled at edge n makes `branch_to_addr_i` the SRAM address after edge n.
- **Simultaneous events:** flush overrides stall and branch. Branch during stall is ignored; decode re-presents the branch after the stall.
- **Stall:** `inst_o`/`pc_o` stay bit-identical for every stalled cycle, regardless of SRAM output.
- **Reset mid-stall:** all state clears asynchronously; the skid buffer is emptied.
- **First cycle after reset release:** `inst_o`=0 (bubble) while `RESET_PC` is fetched.

## Structure
- Shared package `cpu_pkg`: `RESET_PC` value, `ZERO_WORD`, `NOP_INST` (32'h0), and the AdEL exception-code constant.
- One natural sub-module: `pc_reg` holds `pc_q` and the next-PC priority mux. The IF/ID register and skid buffer stay inline.

## Test plan
- **Reset release:** after `rst` 1→0, `inst_sram_addr_o` = BFC00000, then BFC00004. The cycle after that shows `pc_o`=BFC00000 with `inst_o` = the SRAM word.
- **Taken branch:** branch at BFC00010 with target BFC00100. Fetch sequence must be 10, 14 (delay slot, `is_in_delayslot_o`=1), 100, 104.
- **Stall:** 3-cycle `stall_i` with the SRAM model returning garbage while en=0. `pc_o` and `inst_o` must hold the pre-stall word, and the next PC resumes at +4.
- **Flush during stall:** `flush_i`=1, `stall_i`=1, `new_pc_i`=BFC00380. Next cycle `inst_o`=0 with `id_valid` clear, then fetch from BFC00380.
- **Misaligned fetch:** branch to BFC00102. `inst_sram_en_o`=0; next cycle `fetch_adel_o`=1, `pc_o`=BFC00102, `inst_o`=0.
- **Async reset mid-stream:** assert `rst` between edges. Outputs must drop to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the CPU pipeline: reset vector, zero/nop words and the
// exception code raised for a misaligned instruction fetch.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [31:0] NOP_INST  = 32'h0000_0000;

   // Address error on load / instruction fetch.
   localparam logic [4:0]  EXC_ADEL  = 5'h04;

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Fetch program counter with its next-PC priority mux.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall_i             hold the PC
//   flush_i             exception/eret redirect (highest priority)
//   new_pc_i            redirect target for flush_i
//   branch_flag_i       taken branch/jump resolved in decode
//   branch_to_addr_i    branch target
//   pc_o                current fetch PC
// -----------------------------------------------------------------------------
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC_VAL = RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_to_addr_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Flush beats stall; a branch seen while stalled is dropped because decode
   // re-presents it once the stall lifts.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (flush_i) begin
         pc_d = new_pc_i;
      end else if (stall_i) begin
         pc_d = pc_q;
      end else if (branch_flag_i) begin
         pc_d = branch_to_addr_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage plus IF/ID pipeline register. Drives the synchronous
// instruction SRAM from the fetch PC and presents a registered pc/inst/
// delay-slot triple to decode. A one-entry skid buffer keeps inst_o stable
// while stalled, since the SRAM output is not held once its enable drops.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall_i, flush_i          pipeline hold / exception redirect
//   new_pc_i                  flush target
//   branch_flag_i             taken branch from decode
//   branch_to_addr_i          branch target
//   next_is_in_delayslot_i    instruction being fetched is a delay slot
//   inst_sram_en_o            SRAM read enable
//   inst_sram_addr_o          SRAM byte address (fetch PC)
//   inst_sram_rdata_i         SRAM data, one cycle after the address
//   pc_o, inst_o              decode-stage PC and instruction (0 = bubble)
//   is_in_delayslot_o         decode instruction sits in a delay slot
//   fetch_adel_o              decode PC is misaligned (AdEL)
// -----------------------------------------------------------------------------
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_to_addr_i,
   input  logic        next_is_in_delayslot_i,
   output logic        inst_sram_en_o,
   output logic [31:0] inst_sram_addr_o,
   input  logic [31:0] inst_sram_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        is_in_delayslot_o,
   output logic        fetch_adel_o
);

   logic [31:0] pc_q;
   logic        pc_misaligned;

   logic [31:0] id_pc_q;
   logic        id_valid_q;
   logic        id_ds_q;
   logic        id_adel_q;

   logic [31:0] held_q;
   logic        held_valid_q;

   pc_reg #(
      .RESET_PC_VAL     (RESET_PC)
   ) u_pc_reg (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .flush_i          (flush_i),
      .new_pc_i         (new_pc_i),
      .branch_flag_i    (branch_flag_i),
      .branch_to_addr_i (branch_to_addr_i),
      .pc_o             (pc_q)
   );

   assign pc_misaligned    = (pc_q[1:0] != 2'b00);

   // A misaligned PC never touches the SRAM; the AdEL flag travels to decode.
   assign inst_sram_en_o   = !rst && (!stall_i || flush_i) && !pc_misaligned;
   assign inst_sram_addr_o = pc_q;

   // IF/ID register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc_q    <= ZERO_WORD;
         id_valid_q <= 1'b0;
         id_ds_q    <= 1'b0;
         id_adel_q  <= 1'b0;
      end else if (flush_i) begin
         id_pc_q    <= ZERO_WORD;
         id_valid_q <= 1'b0;
         id_ds_q    <= 1'b0;
         id_adel_q  <= 1'b0;
      end else if (!stall_i) begin
         id_pc_q    <= pc_q;
         id_valid_q <= 1'b1;
         id_ds_q    <= next_is_in_delayslot_i;
         id_adel_q  <= pc_misaligned;
      end
   end

   // Skid buffer: on the first stalled cycle the SRAM still shows the word for
   // the decode entry; capture it before the SRAM output goes stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_q       <= ZERO_WORD;
         held_valid_q <= 1'b0;
      end else if (flush_i || !stall_i) begin
         held_valid_q <= 1'b0;
      end else if (id_valid_q && !held_valid_q) begin
         held_q       <= inst_sram_rdata_i;
         held_valid_q <= 1'b1;
      end
   end

   always_comb begin
      inst_o = NOP_INST;
      if (id_valid_q && !id_adel_q) begin
         inst_o = held_valid_q ? held_q : inst_sram_rdata_i;
      end
   end

   assign pc_o              = id_pc_q;
   assign is_in_delayslot_o = id_ds_q;
   assign fetch_adel_o      = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: directed scenarios followed by randomized
// stall/flush/branch traffic, compared against a transaction-level model of the
// fetch PC and the decode slot. The expected instruction is the memory word at
// the decode PC, independent of how the SRAM and skid buffer deliver it.
// -----------------------------------------------------------------------------
module tb_if_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        branch_flag_i;
   logic [31:0] branch_to_addr_i;
   logic        next_is_in_delayslot_i;
   logic        inst_sram_en_o;
   logic [31:0] inst_sram_addr_o;
   logic [31:0] inst_sram_rdata_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        is_in_delayslot_o;
   logic        fetch_adel_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   if_stage #(
      .RESET_PC               (32'hBFC0_0000)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .stall_i                (stall_i),
      .flush_i                (flush_i),
      .new_pc_i               (new_pc_i),
      .branch_flag_i          (branch_flag_i),
      .branch_to_addr_i       (branch_to_addr_i),
      .next_is_in_delayslot_i (next_is_in_delayslot_i),
      .inst_sram_en_o         (inst_sram_en_o),
      .inst_sram_addr_o       (inst_sram_addr_o),
      .inst_sram_rdata_i      (inst_sram_rdata_i),
      .pc_o                   (pc_o),
      .inst_o                 (inst_o),
      .is_in_delayslot_o      (is_in_delayslot_o),
      .fetch_adel_o           (fetch_adel_o)
   );

   // Memory contents: a distinct word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Synchronous SRAM; garbage whenever it is not enabled.
   always @(posedge clk) begin
      if (inst_sram_en_o) inst_sram_rdata_i <= mem_word(inst_sram_addr_o);
      else                inst_sram_rdata_i <= $urandom;
   end

   // Reference model: fetch PC and the instruction held for decode.
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_idpc;
   logic        m_ds;
   logic        m_adel;

   task automatic model_reset();
      m_pc    = 32'hBFC0_0000;
      m_valid = 1'b0;
      m_idpc  = 32'h0;
      m_ds    = 1'b0;
      m_adel  = 1'b0;
   endtask

   function automatic logic [31:0] exp_inst();
      return (m_valid && !m_adel) ? mem_word(m_idpc) : 32'h0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("sram_addr", inst_sram_addr_o, m_pc);
      check_eq("pc_o", pc_o, m_idpc);
      check_eq("inst_o", inst_o, exp_inst());
      check_eq("ds", {31'b0, is_in_delayslot_o}, {31'b0, m_ds});
      check_eq("adel", {31'b0, fetch_adel_o}, {31'b0, m_adel});
   endtask

   // One clock cycle: drive at the negedge, check enable, advance the model at
   // the posedge, check registered outputs at the next negedge.
   task automatic step(input logic st, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt, input logic ds);
      logic exp_en;
      stall_i                = st;
      flush_i                = fl;
      new_pc_i               = npc;
      branch_flag_i          = br;
      branch_to_addr_i       = tgt;
      next_is_in_delayslot_i = ds;
      exp_en = (!st || fl) && (m_pc[1:0] == 2'b00);
      #1;
      check_eq("sram_en", {31'b0, inst_sram_en_o}, {31'b0, exp_en});
      @(posedge clk);
      if (fl) begin
         m_valid = 1'b0;
         m_idpc  = 32'h0;
         m_ds    = 1'b0;
         m_adel  = 1'b0;
         m_pc    = npc;
      end else if (!st) begin
         m_valid = 1'b1;
         m_idpc  = m_pc;
         m_ds    = ds;
         m_adel  = (m_pc[1:0] != 2'b00);
         m_pc    = br ? tgt : m_pc + 32'd4;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run();
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      logic [31:0] pre_pc;
      logic [31:0] pre_inst;
      logic [31:0] tgt;
      logic        st;
      logic        fl;
      logic        br;

      rst                    = 1'b1;
      stall_i                = 1'b0;
      flush_i                = 1'b0;
      new_pc_i               = 32'h0;
      branch_flag_i          = 1'b0;
      branch_to_addr_i       = 32'h0;
      next_is_in_delayslot_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);

      // Reset state
      check_eq("rst_en", {31'b0, inst_sram_en_o}, 32'h0);
      check_eq("rst_addr", inst_sram_addr_o, 32'hBFC0_0000);
      check_eq("rst_pc_o", pc_o, 32'h0);
      check_eq("rst_inst_o", inst_o, 32'h0);

      // Reset release: bubble while RESET_PC is fetched
      rst = 1'b0;
      #1;
      check_eq("rel_addr0", inst_sram_addr_o, 32'hBFC0_0000);
      check_eq("rel_bubble", inst_o, 32'h0);
      run();
      check_eq("rel_addr1", inst_sram_addr_o, 32'hBFC0_0004);
      check_eq("rel_pc_o", pc_o, 32'hBFC0_0000);
      check_eq("rel_inst_o", inst_o, mem_word(32'hBFC0_0000));

      // Taken branch at BFC00010 -> BFC00100, delay slot at BFC00014
      repeat (4) run();
      check_eq("br_pc_at_branch", pc_o, 32'hBFC0_0010);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0100, 1'b1);
      check_eq("br_ds_pc", pc_o, 32'hBFC0_0014);
      check_eq("br_ds_flag", {31'b0, is_in_delayslot_o}, 32'h1);
      run();
      check_eq("br_target", pc_o, 32'hBFC0_0100);
      run();
      check_eq("br_target4", pc_o, 32'hBFC0_0104);

      // 3-cycle stall with SRAM returning garbage
      pre_pc   = pc_o;
      pre_inst = inst_o;
      repeat (3) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         check_eq("stall_pc_hold", pc_o, pre_pc);
         check_eq("stall_inst_hold", inst_o, pre_inst);
      end
      run();
      check_eq("stall_resume", pc_o, pre_pc + 32'd4);

      // Branch during stall is ignored
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0200, 1'b0);
      check_eq("stall_branch_ign", inst_sram_addr_o, pre_pc + 32'd8);

      // Flush during stall
      step(1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 32'hBFC0_0200, 1'b0);
      check_eq("flush_inst", inst_o, 32'h0);
      check_eq("flush_addr", inst_sram_addr_o, 32'hBFC0_0380);
      run();
      check_eq("flush_fetch", pc_o, 32'hBFC0_0380);

      // Misaligned fetch
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0102, 1'b1);
      run();
      check_eq("adel_flag", {31'b0, fetch_adel_o}, 32'h1);
      check_eq("adel_pc", pc_o, 32'hBFC0_0102);
      check_eq("adel_inst", inst_o, 32'h0);
      run();

      // Async reset in the middle of a stall
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_pc_o", pc_o, 32'h0);
      check_eq("arst_inst_o", inst_o, 32'h0);
      check_eq("arst_ds", {31'b0, is_in_delayslot_o}, 32'h0);
      check_eq("arst_adel", {31'b0, fetch_adel_o}, 32'h0);
      check_eq("arst_en", {31'b0, inst_sram_en_o}, 32'h0);
      check_eq("arst_addr", inst_sram_addr_o, 32'hBFC0_0000);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outputs();
      run();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         st  = ($urandom_range(0, 99) < 25);
         fl  = ($urandom_range(0, 99) < 5);
         br  = ($urandom_range(0, 99) < 15);
         tgt = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC);
         if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         step(st, fl, 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC), br, tgt,
              br ? 1'b1 : 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
